// File: rtl/snes_reader_if.sv
// Controller-side and CPU-side signals of one SNES poller.
// master = poller (drives latch/clock and the published word), slave = controller/consumer side.
interface snes_reader_if;
    logic        snes_serial;
    logic        snes_latch;
    logic        snes_clk;
    logic [11:0] snes_data;
    logic        data_valid;

    modport master (
        input  snes_serial,
        output snes_latch,
        output snes_clk,
        output snes_data,
        output data_valid
    );

    modport slave (
        output snes_serial,
        input  snes_latch,
        input  snes_clk,
        input  snes_data,
        input  data_valid
    );
endinterface

// File: rtl/snes_reader.sv
// Polls one SNES controller: generates latch/clock, shifts in 16 bits and
// republishes the 12 button bits (1 = pressed) once per poll period.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for the poll counter to wrap to 0
// S_LATCH    | snes_latch high for 2*CLK_DIV cycles
// S_CLK_LOW  | snes_clk low for CLK_DIV cycles, sample on last cycle
// S_CLK_HIGH | snes_clk high for CLK_DIV cycles, advance bit index
// S_DONE     | one cycle: publish inverted capture, pulse data_valid
module snes_reader #(
    parameter int CLK_DIV     = 300,
    parameter int POLL_CYCLES = 833333
) (
    input  logic          clk,
    input  logic          reset,
    snes_reader_if.master bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LATCH    = 3'd1;
    localparam logic [2:0] S_CLK_LOW  = 3'd2;
    localparam logic [2:0] S_CLK_HIGH = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam int TW = $clog2(2 * CLK_DIV);
    localparam int PW = $clog2(POLL_CYCLES);
    localparam logic [TW-1:0] LATCH_LOAD = TW'(2 * CLK_DIV - 1);
    localparam logic [TW-1:0] HALF_LOAD  = TW'(CLK_DIV - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [PW-1:0] poll_cnt;
    logic [3:0]    bit_idx;
    logic [15:0]   shift_q;
    logic [1:0]    sync_q;
    logic          serial_s;
    logic          latch_q;
    logic          sclk_q;
    logic [11:0]   data_q;
    logic          valid_q;

    assign serial_s       = sync_q[1];
    assign bus.snes_latch = latch_q;
    assign bus.snes_clk   = sclk_q;
    assign bus.snes_data  = data_q;
    assign bus.data_valid = valid_q;

    // Pin is idle-high, so the synchronizer comes out of reset as "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.snes_serial};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= '0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            latch_q <= 1'b0;
            sclk_q  <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (poll_cnt == '0) begin
                        state   <= S_LATCH;
                        latch_q <= 1'b1;
                        timer   <= LATCH_LOAD;
                    end
                end
                S_LATCH: begin
                    if (timer == '0) begin
                        state   <= S_CLK_LOW;
                        latch_q <= 1'b0;
                        sclk_q  <= 1'b0;
                        timer   <= HALF_LOAD;
                        bit_idx <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_CLK_LOW: begin
                    if (timer == '0) begin
                        shift_q[bit_idx] <= serial_s;
                        state            <= S_CLK_HIGH;
                        sclk_q           <= 1'b1;
                        timer            <= HALF_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_CLK_HIGH: begin
                    if (timer == '0) begin
                        if (bit_idx == 4'd15) begin
                            state   <= S_DONE;
                            data_q  <= ~shift_q[11:0];
                            valid_q <= 1'b1;
                        end else begin
                            state   <= S_CLK_LOW;
                            sclk_q  <= 1'b0;
                            timer   <= HALF_LOAD;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snes_reader.sv
// Bench for snes_reader: behavioural controller model plus a scoreboard of
// expected button words checked at each data_valid pulse.
module tb_snes_reader;
    localparam int CLK_DIV = 4;
    localparam int POLL    = 200;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    snes_reader_if ifc();

    snes_reader #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] pattern = 16'hFFFF;
    logic [4:0]  bit_pos = 5'd16;
    logic [11:0] sb[$];

    // Controller: latch loads bit 0, each rising snes_clk presents the next bit.
    always @(posedge ifc.snes_latch or posedge ifc.snes_clk) begin
        if (ifc.snes_latch) bit_pos = 5'd0;
        else if (bit_pos < 5'd16) bit_pos = bit_pos + 5'd1;
    end
    assign ifc.snes_serial = (bit_pos < 5'd16) ? pattern[bit_pos[3:0]] : 1'b1;

    int          ncyc = 0;
    int          rises[$];
    logic        prev_latch = 1'b0;
    logic [11:0] prev_data = 12'h000;
    int          unstable = 0;

    always @(negedge clk) begin
        ncyc++;
        if (ifc.snes_latch === 1'b1 && prev_latch === 1'b0) rises.push_back(ncyc);
        prev_latch = ifc.snes_latch;
        if (!reset && ifc.snes_data !== prev_data && ifc.data_valid !== 1'b1) unstable++;
        prev_data = ifc.snes_data;
    end

    task automatic wait_valid(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifc.data_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ifc.snes_latch !== 1'b0) begin
            errors++; $display("FAIL reset_latch: got %b want 0", ifc.snes_latch);
        end
        checks++;
        if (ifc.snes_clk !== 1'b1) begin
            errors++; $display("FAIL reset_sclk: got %b want 1", ifc.snes_clk);
        end
        checks++;
        if (ifc.snes_data !== 12'h000) begin
            errors++; $display("FAIL reset_data: got %h want 000", ifc.snes_data);
        end
        checks++;
        if (ifc.data_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", ifc.data_valid);
        end
    endtask

    task automatic test_frame_waveform();
        int first_latch = -1, latch_cnt = 0, low_run = 0, pulses = 0, bad_width = 0;
        int valid_at = -1, valid_cnt = 0;
        logic [11:0] seen = 12'hxxx;
        logic [11:0] exp;
        pattern = 16'hFFFF;
        sb.push_back(12'h000);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 140; n++) begin
            @(negedge clk);
            if (ifc.snes_latch === 1'b1) begin
                latch_cnt++;
                if (first_latch < 0) first_latch = n;
            end
            if (ifc.snes_clk === 1'b0) low_run++;
            else if (low_run > 0) begin
                pulses++;
                if (low_run != CLK_DIV) bad_width++;
                low_run = 0;
            end
            if (ifc.data_valid === 1'b1) begin
                valid_cnt++;
                if (valid_at < 0) begin
                    valid_at = n;
                    seen = ifc.snes_data;
                end
            end
        end
        checks++;
        if (first_latch != 0) begin
            errors++; $display("FAIL wave_latch_start: got %0d want 0", first_latch);
        end
        checks++;
        if (latch_cnt != 2 * CLK_DIV) begin
            errors++; $display("FAIL wave_latch_len: got %0d want %0d", latch_cnt, 2 * CLK_DIV);
        end
        checks++;
        if (pulses != 16) begin
            errors++; $display("FAIL wave_pulses: got %0d want 16", pulses);
        end
        checks++;
        if (bad_width != 0) begin
            errors++; $display("FAIL wave_pulse_width: got %0d bad pulses want 0", bad_width);
        end
        checks++;
        if (valid_at != 34 * CLK_DIV) begin
            errors++; $display("FAIL wave_valid_time: got %0d want %0d", valid_at, 34 * CLK_DIV);
        end
        checks++;
        if (valid_cnt != 1) begin
            errors++; $display("FAIL wave_valid_count: got %0d want 1", valid_cnt);
        end
        exp = sb.pop_front();
        checks++;
        if (seen !== exp) begin
            errors++; $display("FAIL wave_data: got %h want %h", seen, exp);
        end
    endtask

    task automatic test_button_pattern();
        bit to;
        logic [11:0] exp;
        pattern = 16'h07F6;
        sb.push_back(12'h809);
        wait_valid(300, to);
        exp = sb.pop_front();
        checks++;
        if (to || ifc.snes_data !== exp) begin
            errors++; $display("FAIL button_data: got %h (timeout %0d) want %h", ifc.snes_data, to, exp);
        end
    endtask

    task automatic test_all_pressed();
        bit to;
        logic [11:0] exp;
        pattern = 16'h0000;
        sb.push_back(12'hFFF);
        wait_valid(300, to);
        exp = sb.pop_front();
        checks++;
        if (to || ifc.snes_data !== exp) begin
            errors++; $display("FAIL all_pressed: got %h (timeout %0d) want %h", ifc.snes_data, to, exp);
        end
        pattern = 16'hFFFF;
        sb.push_back(12'h000);
        wait_valid(300, to);
        exp = sb.pop_front();
        checks++;
        if (to || ifc.snes_data !== exp) begin
            errors++; $display("FAIL all_released: got %h (timeout %0d) want %h", ifc.snes_data, to, exp);
        end
    endtask

    task automatic test_periodicity();
        checks++;
        if (rises.size() < 3) begin
            errors++; $display("FAIL period_rises: got %0d latch rises want >= 3", rises.size());
        end else begin
            if (rises[1] - rises[0] != POLL) begin
                errors++; $display("FAIL period_second: got %0d want %0d", rises[1] - rises[0], POLL);
            end
            checks++;
            if (rises[2] - rises[0] != 2 * POLL) begin
                errors++; $display("FAIL period_third: got %0d want %0d", rises[2] - rises[0], 2 * POLL);
            end
        end
        checks++;
        if (unstable != 0) begin
            errors++; $display("FAIL data_stable: got %0d changes without data_valid want 0", unstable);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int waited, valid_cnt, first_latch, valid_at;
        logic [11:0] exp, seen;
        pattern = 16'h07F6;
        sb.push_back(12'h809);
        wait_valid(300, to);
        exp = sb.pop_front();
        checks++;
        if (to || ifc.snes_data !== exp) begin
            errors++; $display("FAIL premid_data: got %h (timeout %0d) want %h", ifc.snes_data, to, exp);
        end
        pattern = 16'h0000;
        waited = 0;
        while (ifc.snes_latch !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        repeat (65) @(negedge clk);
        checks++;
        if (ifc.snes_clk !== 1'b0) begin
            errors++; $display("FAIL mid_bit7_low: got %b want 0", ifc.snes_clk);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ifc.snes_latch !== 1'b0 || ifc.snes_clk !== 1'b1 || ifc.snes_data !== 12'h000 || ifc.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got latch %b sclk %b data %h valid %b want 0 1 000 0",
                     ifc.snes_latch, ifc.snes_clk, ifc.snes_data, ifc.data_valid);
        end
        valid_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.data_valid === 1'b1) valid_cnt++;
        end
        checks++;
        if (valid_cnt != 0) begin
            errors++; $display("FAIL mid_no_valid: got %0d pulses want 0", valid_cnt);
        end
        pattern = 16'h0F3C;
        sb.push_back(~pattern[11:0]);
        reset = 1'b0;
        first_latch = -1;
        valid_at = -1;
        seen = 12'hxxx;
        for (int n = 0; n < 140; n++) begin
            @(negedge clk);
            if (ifc.snes_latch === 1'b1 && first_latch < 0) first_latch = n;
            if (ifc.data_valid === 1'b1 && valid_at < 0) begin
                valid_at = n;
                seen = ifc.snes_data;
            end
        end
        checks++;
        if (first_latch != 0) begin
            errors++; $display("FAIL mid_restart_latch: got %0d want 0", first_latch);
        end
        checks++;
        if (valid_at != 34 * CLK_DIV) begin
            errors++; $display("FAIL mid_restart_valid: got %0d want %0d", valid_at, 34 * CLK_DIV);
        end
        exp = sb.pop_front();
        checks++;
        if (seen !== exp) begin
            errors++; $display("FAIL mid_restart_data: got %h want %h", seen, exp);
        end
    endtask

    initial begin
        test_reset();
        test_frame_waveform();
        test_button_pattern();
        test_all_pressed();
        test_periodicity();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snes_reader.md
# snes_reader

Polls one SNES game controller over its three-wire serial interface and presents the current button state as a 12-bit parallel word. One instance drives each controller input of the CPU control state machine: `snes_data` for controller 0 and `snes_data1` for controller 1. That state machine copies the word into a register when it executes the controller-read instruction. The block generates the latch and clock waveforms, shifts in 16 serial bits, and republishes a new word once per poll period.

## Interface
- `CLK_DIV`, default 300 — half-period of `snes_clk` in `clk` cycles (6 µs at 50 MHz); legal range ≥ 4.
- `POLL_CYCLES`, default 833333 — poll period in `clk` cycles (about 60 Hz); must be ≥ 34*CLK_DIV + 2.

- `clk` input 1 — system clock; all logic is on the rising edge.
- `reset` input 1 — asynchronous, active-high; one clock domain only.
- `snes_serial` input 1 — controller data pin; active-low (0 = pressed); asynchronous to `clk`.
- `snes_latch` output 1 — controller latch pulse, active-high.
- `snes_clk` output 1 — controller shift clock; idles high.
- `snes_data` output 12 — button state, 1 = pressed; bit 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R.
- `data_valid` output 1 — one-cycle pulse when `snes_data` updates.

## Operation
- **Input synchronizer:** `snes_serial` passes through a 2-flop synchronizer. Both flops reset to 1. All sampling uses the synchronizer output.
- **Poll counter:** free-running, counts 0..POLL_CYCLES-1, then wraps to 0. Resets to 0.
- **State machine:** states are IDLE, LATCH, CLK_LOW, CLK_HIGH, DONE; reset state is IDLE.
  - IDLE → LATCH when the poll counter equals 0.
  - LATCH holds for 2*CLK_DIV cycles with `snes_latch`=1, then → CLK_LOW with bit index 0.
  - CLK_LOW holds for CLK_DIV cycles with `snes_clk`=0. On its last cycle it samples the synchronized serial bit into shift position [bit index], then → CLK_HIGH.
  - CLK_HIGH holds for CLK_DIV cycles with `snes_clk`=1. Then it goes to CLK_LOW with bit index+1 if bit index < 15, else → DONE.
  - DONE lasts one cycle: `snes_data` ← ~captured[11:0] and `data_valid`=1, then → IDLE.
- **Bit handling:** all 16 bits are clocked out of the controller. Captured bits 12–15 are discarded.
- **Output registers:** `snes_data` holds its value between DONE cycles. The CPU may read it on any cycle.
- **Reset values:** `snes_latch`=0, `snes_clk`=1, `snes_data`=12'h000, `data_valid`=0. The synchronizer flops, shift register, bit index and counters all reset to 0 or idle.
- **Reset mid-frame:** the frame is aborted immediately (asynchronous). Outputs go to their reset values, no `data_valid` pulse is issued, and partial capture data is discarded.
- **Controller absent:** with the pin pulled high, every bit reads 1 and `snes_data` = 12'h000. No presence detection is performed.

## Timing
- Let T0 be the first cycle with `snes_latch`=1. T0 is the first rising edge after `reset` deasserts, and every POLL_CYCLES cycles after that.
- `snes_latch`=1 during cycles T0 .. T0+2D-1, where D = CLK_DIV.
- Bit k (k = 0..15) low phase: cycles T0+2D+2kD .. T0+2D+2kD+D-1. The high phase is the following D cycles.
- Bit k is sampled at cycle T0+3D+2kD-1, i.e. the last low cycle, just before the rising edge at which the controller presents bit k+1.
- DONE occurs at T0+34D: `data_valid`=1 and the new `snes_data` are visible from that cycle onward.
- Frame length is 34D+1 cycles. IDLE covers the remainder of the poll period.
- Worst-case `snes_serial` settling margin before sampling is D-1 cycles. The 2-cycle synchronizer latency plus 1 cycle of margin requires D ≥ 4.
- All outputs are registered and glitch-free.

## Test plan
- **Reset values:** hold `reset` high → `snes_latch`=0, `snes_clk`=1, `snes_data`=12'h000, `data_valid`=0.
- **Frame waveform** (CLK_DIV=4, POLL_CYCLES=200, controller model releases all buttons):
  - `snes_latch` is high for exactly 8 cycles starting at the first cycle after reset release.
  - Exactly 16 `snes_clk` low pulses of 4 cycles each occur.
  - `data_valid` pulses once at T0+136; `snes_data`=12'h000.
- **Button pattern:** model drives bits 0, 3 and 11 low (B, Start, R) and the others high → `snes_data`=12'h809 at T0+136. Bits 12–15 driven low have no effect.
- **All pressed:** model holds `snes_serial`=0 → `snes_data`=12'hFFF. The next frame with the line released → 12'h000, updated only at that frame's DONE cycle.
- **Periodicity:** second `snes_latch` rise at T0+200, third at T0+400. `snes_data` is stable between `data_valid` pulses.
- **Reset mid-frame:** assert `reset` during bit 7's low phase → outputs return to reset values the same cycle with no `data_valid`. After release, a complete new frame starts at the first cycle and its captured data is correct.
